ikaopll_hostwriter: RTL and testbench

IKAOPLL_HOSTWRITER -- requirements
Module: IKAOPLL_hostwriter

---
 rtl/ikaopll_hostwriter.sv | 233 +++++++++++++++++++++++
 tb/tb_ikaopll_hostwriter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ikaopll_hostwriter.sv
// ----------------------------------------------------------------------------
// ikaopll_hostwriter
//
// Purpose:
//   Turns simple host register-write requests (address + data) into the
//   two-phase OPLL bus cycle: an address-port write (A0=0), a post-address
//   wait, a data-port write (A0=1), and a post-data wait. Each bus phase is
//   timed in phiM ticks, where a tick is a rising i_EMUCLK edge with
//   i_phiM_PCEN_n low. The last address that reached the chip is remembered.
//   A request to that same address skips the address phase and goes straight
//   to the data write.
//
// Handshake:
//   A request is taken on any i_EMUCLK edge where i_REQ_VALID and o_REQ_READY
//   are both high. o_REQ_READY is high only in IDLE. While the writer is busy,
//   i_REQ_VALID, i_REQ_ADDR and i_REQ_DATA are ignored. The host must hold a
//   request until it is taken. Every accepted request is performed exactly
//   once, or dropped by a reset.
//
// Ports:
//   i_EMUCLK       master clock; every flop is clocked on its rising edge
//   i_IC_n         synchronous active-low reset
//   i_phiM_PCEN_n  active-low phiM tick enable
//   i_REQ_VALID    host write request pending
//   i_REQ_ADDR     OPLL register address (8 bits)
//   i_REQ_DATA     OPLL register data (8 bits)
//   o_REQ_READY    writer is idle and can take a request (combinational)
//   o_CS_n         chip select to the OPLL, active low (registered)
//   o_WR_n         write strobe to the OPLL, active low (registered)
//   o_A0           0 = address port, 1 = data port (registered)
//   o_D            bus data (registered)
//   o_D_OE         bus output enable (registered)
//   o_BUSY         writer is not idle (combinational)
//   o_DBG_STATE    current FSM state encoding, for observation only
// ----------------------------------------------------------------------------
module ikaopll_hostwriter #(
    parameter int SETUP_TICKS     = 1,   // 1..7
    parameter int STROBE_TICKS    = 2,   // 1..7
    parameter int ADDR_WAIT_TICKS = 12,  // 1..127
    parameter int DATA_WAIT_TICKS = 84   // 1..127
) (
    input  logic       i_EMUCLK,
    input  logic       i_IC_n,
    input  logic       i_phiM_PCEN_n,
    input  logic       i_REQ_VALID,
    input  logic [7:0] i_REQ_ADDR,
    input  logic [7:0] i_REQ_DATA,
    output logic       o_REQ_READY,
    output logic       o_CS_n,
    output logic       o_WR_n,
    output logic       o_A0,
    output logic [7:0] o_D,
    output logic       o_D_OE,
    output logic       o_BUSY,
    output logic [2:0] o_DBG_STATE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_WAIT   = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_WAIT   = 3'd6
    } state_t;

    // A state that lasts N ticks loads N-1 on entry. It leaves on the tick
    // that finds the counter at zero.
    localparam logic [6:0] SETUP_LD  = 7'(SETUP_TICKS - 1);
    localparam logic [6:0] STROBE_LD = 7'(STROBE_TICKS - 1);
    localparam logic [6:0] AWAIT_LD  = 7'(ADDR_WAIT_TICKS - 1);
    localparam logic [6:0] DWAIT_LD  = 7'(DATA_WAIT_TICKS - 1);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] cache_addr_q, cache_addr_d;
    logic       cache_valid_q, cache_valid_d;
    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       a0_q, a0_d;
    logic [7:0] dbus_q, dbus_d;
    logic       d_oe_q, d_oe_d;

    logic tick;
    assign tick = ~i_phiM_PCEN_n;

    // ------------------------------------------------------------------
    // State register and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_EMUCLK) begin
        if (!i_IC_n) begin
            state_q       <= IDLE;
            cnt_q         <= 7'd0;
            addr_q        <= 8'h00;
            data_q        <= 8'h00;
            cache_addr_q  <= 8'h00;
            cache_valid_q <= 1'b0;
            cs_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            a0_q          <= 1'b0;
            dbus_q        <= 8'h00;
            d_oe_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            cache_addr_q  <= cache_addr_d;
            cache_valid_q <= cache_valid_d;
            cs_n_q        <= cs_n_d;
            wr_n_q        <= wr_n_d;
            a0_q          <= a0_d;
            dbus_q        <= dbus_d;
            d_oe_q        <= d_oe_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, counter, request latch and address cache
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        cache_addr_d  = cache_addr_q;
        cache_valid_d = cache_valid_q;

        case (state_q)
            IDLE: begin
                // Requests are taken on any clock edge, not only on ticks.
                if (i_REQ_VALID) begin
                    addr_d = i_REQ_ADDR;
                    data_d = i_REQ_DATA;
                    cnt_d  = SETUP_LD;
                    if (cache_valid_q && (i_REQ_ADDR == cache_addr_q)) begin
                        state_d = D_SETUP;
                    end else begin
                        state_d = A_SETUP;
                    end
                end
            end
            default: begin
                // Timed states move only on ticks. Other edges leave the
                // counter and the state frozen.
                if (tick) begin
                    if (cnt_q != 7'd0) begin
                        cnt_d = cnt_q - 7'd1;
                    end else begin
                        case (state_q)
                            A_SETUP: begin
                                state_d = A_STROBE;
                                cnt_d   = STROBE_LD;
                            end
                            A_STROBE: begin
                                // The address has now been strobed into the
                                // chip, so it is the one to remember.
                                state_d       = A_WAIT;
                                cnt_d         = AWAIT_LD;
                                cache_addr_d  = addr_q;
                                cache_valid_d = 1'b1;
                            end
                            A_WAIT: begin
                                state_d = D_SETUP;
                                cnt_d   = SETUP_LD;
                            end
                            D_SETUP: begin
                                state_d = D_STROBE;
                                cnt_d   = STROBE_LD;
                            end
                            D_STROBE: begin
                                state_d = D_WAIT;
                                cnt_d   = DWAIT_LD;
                            end
                            default: begin
                                // D_WAIT, and any unused encoding, go back
                                // to IDLE.
                                state_d = IDLE;
                                cnt_d   = 7'd0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus output decode. It uses the state being entered, so the
    // registered pins change on the same edge as the state register.
    // ------------------------------------------------------------------
    always_comb begin
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        d_oe_d = 1'b0;
        a0_d   = a0_q;
        dbus_d = dbus_q;

        case (state_d)
            A_SETUP, A_STROBE: begin
                cs_n_d = 1'b0;
                d_oe_d = 1'b1;
                a0_d   = 1'b0;
                dbus_d = addr_d;
                wr_n_d = (state_d != A_STROBE);
            end
            D_SETUP, D_STROBE: begin
                cs_n_d = 1'b0;
                d_oe_d = 1'b1;
                a0_d   = 1'b1;
                dbus_d = data_d;
                wr_n_d = (state_d != D_STROBE);
            end
            default: begin
                // In the idle and wait states the bus is released. A0 and D
                // keep their last values.
            end
        endcase
    end

    assign o_REQ_READY = (state_q == IDLE);
    assign o_BUSY      = (state_q != IDLE);
    assign o_DBG_STATE = state_q;
    assign o_CS_n      = cs_n_q;
    assign o_WR_n      = wr_n_q;
    assign o_A0        = a0_q;
    assign o_D         = dbus_q;
    assign o_D_OE      = d_oe_q;

endmodule

// File: tb/tb_ikaopll_hostwriter.sv
// ----------------------------------------------------------------------------
// Bench for ikaopll_hostwriter at default timing: tick every 2nd clock.
// Each bus strobe is turned into one record:
//   {A0, D, WR_n-low ticks, ticks until the next bus access or idle}.
// Each transaction is turned into one record:
//   {first state after acceptance, ticks spent busy}.
// The send task queues the expected records. The monitor builds the observed
// records from the pins and compares them against the queues.
// ----------------------------------------------------------------------------
module tb_ikaopll_hostwriter;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_A_SETUP  = 3'd1;
    localparam logic [2:0] S_A_WAIT   = 3'd3;
    localparam logic [2:0] S_D_SETUP  = 3'd4;
    localparam logic [2:0] S_D_STROBE = 3'd5;

    logic       clk = 1'b0;
    logic       ic_n = 1'b0;
    logic       pcen_n = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       ready, cs_n, wr_n, a0, d_oe, busy;
    logic [7:0] dbus;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [24:0] exp_st_q[$];
    logic [10:0] exp_tx_q[$];

    bit         freeze = 1'b0;
    bit         mon_flush = 1'b1;
    bit         last_tick = 1'b0;
    bit         mvalid = 1'b0;
    logic [7:0] mcache = 8'h00;

    ikaopll_hostwriter dut (
        .i_EMUCLK      (clk),
        .i_IC_n        (ic_n),
        .i_phiM_PCEN_n (pcen_n),
        .i_REQ_VALID   (req_valid),
        .i_REQ_ADDR    (req_addr),
        .i_REQ_DATA    (req_data),
        .o_REQ_READY   (ready),
        .o_CS_n        (cs_n),
        .o_WR_n        (wr_n),
        .o_A0          (a0),
        .o_D           (dbus),
        .o_D_OE        (d_oe),
        .o_BUSY        (busy),
        .o_DBG_STATE   (dbg_state)
    );

    // ---------------- clock / tick enable ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (freeze) pcen_n = 1'b1;
        else        pcen_n = ~pcen_n;
    end

    always @(posedge clk) last_tick = ~pcen_n;

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_busy = 0, in_strobe = 0, in_wait = 0;
    int         busy_ticks = 0, st_cnt = 0, wt_cnt = 0;
    logic [2:0] first_state = 3'd0;
    logic       cap_a0 = 1'b0;
    logic [7:0] cap_d = 8'h00;

    always @(negedge clk) begin
        if (mon_flush) begin
            in_busy   = 0;
            in_strobe = 0;
            in_wait   = 0;
        end else begin
            if (in_busy && last_tick) busy_ticks++;
            if (!in_busy && busy) begin
                in_busy     = 1;
                busy_ticks  = 0;
                first_state = dbg_state;
            end else if (in_busy && !busy) begin
                in_busy = 0;
                if (exp_tx_q.size() == 0) check("txn_unexpected", 32'({first_state, 8'(busy_ticks)}), 32'h7ff);
                else check("txn", 32'({first_state, 8'(busy_ticks)}), 32'(exp_tx_q.pop_front()));
            end

            if (in_strobe && last_tick) st_cnt++;
            if (in_wait && last_tick) wt_cnt++;
            if (!in_strobe && !in_wait && !wr_n) begin
                in_strobe = 1;
                st_cnt    = 0;
                cap_a0    = a0;
                cap_d     = dbus;
            end else if (in_strobe && wr_n) begin
                in_strobe = 0;
                in_wait   = 1;
                wt_cnt    = 0;
            end else if (in_wait && (!cs_n || !busy)) begin
                in_wait = 0;
                if (exp_st_q.size() == 0)
                    check("strobe_unexpected", 32'({cap_a0, cap_d, 8'(st_cnt), 8'(wt_cnt)}), 32'h1ffffff);
                else
                    check("strobe", 32'({cap_a0, cap_d, 8'(st_cnt), 8'(wt_cnt)}), 32'(exp_st_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] d, input bit push);
        bit hit;
        int n;
        hit = mvalid && (a == mcache);
        if (push) begin
            if (!hit) exp_st_q.push_back({1'b0, a, 8'd2, 8'd12});
            exp_st_q.push_back({1'b1, d, 8'd2, 8'd84});
            exp_tx_q.push_back({(hit ? S_D_SETUP : S_A_SETUP), (hit ? 8'd87 : 8'd102)});
        end
        mcache    = a;
        mvalid    = 1'b1;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n;
        n = 0;
        while (dbg_state != s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (dbg_state != s) check(name, 32'(dbg_state), 32'(s));
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_cs_n"},  32'(cs_n),  32'd1);
        check({tag, "_wr_n"},  32'(wr_n),  32'd1);
        check({tag, "_d_oe"},  32'(d_oe),  32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"},  32'(busy),  32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ic_n = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_bus("reset");
        check("reset_a0", 32'(a0), 32'd0);
        check("reset_d", 32'(dbus), 32'h00);
        check("reset_state", 32'(dbg_state), 32'(S_IDLE));
        ic_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_flush = 1'b0;

        // Full write, then a write to the same address handed over back to back.
        send(8'h10, 8'h55, 1);
        send(8'h10, 8'hAA, 1);
        check("b2b_state", 32'(dbg_state), 32'(S_D_SETUP));
        check("b2b_cs_n", 32'(cs_n), 32'd0);
        check("b2b_a0", 32'(a0), 32'd1);
        check("b2b_d", 32'(dbus), 32'hAA);
        wait_idle();

        // Two different addresses each need an address phase. A repeat of the
        // second address hits the cache.
        send(8'h20, 8'h01, 1);
        send(8'h21, 8'h02, 1);
        send(8'h21, 8'h03, 1);
        wait_idle();

        // Hold the tick enable off in the middle of the address wait.
        send(8'h30, 8'h11, 1);
        wait_state(S_A_WAIT, "freeze_reach_await");
        repeat (4) @(negedge clk);
        freeze = 1'b1;
        repeat (50) @(negedge clk);
        check("freeze_state", 32'(dbg_state), 32'(S_A_WAIT));
        check("freeze_cs_n", 32'(cs_n), 32'd1);
        check("freeze_d_oe", 32'(d_oe), 32'd0);
        check("freeze_a0", 32'(a0), 32'd0);
        check("freeze_d", 32'(dbus), 32'h30);
        freeze = 1'b0;
        wait_idle();

        // Noise on the request inputs while busy must not reach the bus.
        send(8'h40, 8'h99, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 255));
            req_data  = 8'($urandom_range(0, 255));
        end
        req_valid = 1'b0;
        wait_idle();

        // Reset during the data strobe aborts the write and clears the cache.
        send(8'h40, 8'h77, 0);
        wait_state(S_D_STROBE, "abort_reach_dstrobe");
        mon_flush = 1'b1;
        ic_n = 1'b0;
        @(negedge clk);
        check_idle_bus("abort");
        check("abort_a0", 32'(a0), 32'd0);
        check("abort_d", 32'(dbus), 32'h00);
        ic_n   = 1'b1;
        mvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_retry", 32'(busy), 32'd0);
        mon_flush = 1'b0;
        send(8'h40, 8'h78, 1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("strobe_queue_left", 32'(exp_st_q.size()), 32'd0);
        check("txn_queue_left", 32'(exp_tx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
